// File: rtl/pattern_delay_timer_if.sv
// Bus between the serial command source/consumer and pattern_delay_timer.
// The master drives data, abort and ack. The slave (the timer) drives the status outputs.
interface pattern_delay_timer_if #(
  parameter int DELAY_W = 4
) ();
  logic               data;
  logic               abort;
  logic               ack;
  logic               shift_ena;
  logic               counting;
  logic [DELAY_W-1:0] count;
  logic               done;

  modport master (
    output data, abort, ack,
    input  shift_ena, counting, count, done
  );

  modport slave (
    input  data, abort, ack,
    output shift_ena, counting, count, done
  );
endinterface

// File: rtl/pattern_delay_timer.sv
// Finds PATTERN in a serial stream, then shifts in a DELAY_W-bit delay MSB-first.
// It times (delay+1)*TICK cycles, then holds done until ack. abort returns it to SEARCH.
module pattern_delay_timer #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
  parameter int               DELAY_W = 4,
  parameter int               TICK    = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  pattern_delay_timer_if.slave  bus
);

  localparam int PS_W   = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam int BIT_W  = (DELAY_W > 1) ? $clog2(DELAY_W) : 1;

  localparam logic [PS_W-1:0]   PS_LOAD    = PS_W'(TICK - 1);
  localparam logic [FILL_W-1:0] FILL_MAX   = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MATCH = FILL_W'(PAT_W - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(DELAY_W - 1);

  typedef enum logic [1:0] {SEARCH, SHIFT, COUNT, DONE} state_e;

  state_e             state_q, state_d;
  logic [PAT_W-2:0]   hist_q,  hist_d;
  logic [FILL_W-1:0]  fill_q,  fill_d;
  logic [BIT_W-1:0]   bit_q,   bit_d;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic [PS_W-1:0]    presc_q, presc_d;

  logic [PAT_W-1:0]   window;
  logic [DELAY_W:0]   delay_shift;
  logic               match;

  // The window includes the bit arriving this cycle, so a match is seen on the final pattern bit.
  assign window      = {hist_q, bus.data};
  assign delay_shift = {delay_q, bus.data};
  assign match       = (fill_q >= FILL_MATCH) && (window == PATTERN);

  // NOTE: sequential state uses non-blocking assignments only.
  // Blocking assignments here would let one register's update leak into another within the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEARCH;
      hist_q  <= '0;
      fill_q  <= '0;
      bit_q   <= '0;
      delay_q <= '0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      bit_q   <= bit_d;
      delay_q <= delay_d;
      presc_q <= presc_d;
    end
  end

  // NOTE: every *_d gets a default before the case, so no path can infer a latch.
  // History, fill count and bit counter default to zero, which clears them whenever SEARCH is (re)entered.
  always_comb begin
    state_d = state_q;
    hist_d  = '0;
    fill_d  = '0;
    bit_d   = '0;
    delay_d = delay_q;
    presc_d = presc_q;

    unique case (state_q)
      SEARCH: begin
        if (!bus.abort) begin
          if (match) begin
            state_d = SHIFT;
          end else begin
            hist_d = window[PAT_W-2:0];
            fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
          end
        end
      end
      SHIFT: begin
        delay_d = delay_shift[DELAY_W-1:0];
        bit_d   = bit_q + 1'b1;
        if (bit_q == BIT_LAST) begin
          state_d = COUNT;
          bit_d   = '0;
          presc_d = PS_LOAD;
        end
      end
      COUNT: begin
        if (presc_q == '0) begin
          if (delay_q == '0) begin
            state_d = DONE;
          end else begin
            delay_d = delay_q - 1'b1;
            presc_d = PS_LOAD;
          end
        end else begin
          presc_d = presc_q - 1'b1;
        end
      end
      DONE: begin
        if (bus.ack) state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase

    // abort outranks every normal transition outside SEARCH
    if (bus.abort && (state_q != SEARCH)) begin
      state_d = SEARCH;
      delay_d = '0;
      presc_d = '0;
      bit_d   = '0;
    end
  end

  always_comb begin
    bus.shift_ena = (state_q == SHIFT);
    bus.counting  = (state_q == COUNT);
    bus.done      = (state_q == DONE);
    bus.count     = delay_q;
  end

endmodule

// File: tb/tb_pattern_delay_timer.sv
// Self-checking bench for pattern_delay_timer (PATTERN=1101, DELAY_W=4, TICK=4).
// An abstract model (bit queue plus a remaining-cycle budget) is compared against the DUT every cycle.
module tb_pattern_delay_timer;

  localparam int               PAT_W   = 4;
  localparam logic [PAT_W-1:0] PATTERN = 4'b1101;
  localparam int               DELAY_W = 4;
  localparam int               TICK    = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pattern_delay_timer_if #(.DELAY_W(DELAY_W)) bus ();

  pattern_delay_timer #(
    .PAT_W  (PAT_W),
    .PATTERN(PATTERN),
    .DELAY_W(DELAY_W),
    .TICK   (TICK)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model phases: 0 searching, 1 capturing delay, 2 timing, 3 waiting for ack.
  int   m_phase = 0;
  logic m_bits[$];
  int   m_shift_n = 0;
  int   m_delay = 0;
  int   m_rem = 0;
  int   seen_counts[$];

  function automatic void model_step(input logic d, input logic ab, input logic ak, input logic rst);
    if (rst) begin
      m_phase = 0;
      m_bits.delete();
      return;
    end
    case (m_phase)
      0: begin
        if (ab) begin
          m_bits.delete();
        end else begin
          m_bits.push_back(d);
          if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
          if (m_bits.size() == PAT_W) begin
            int v = 0;
            foreach (m_bits[i]) v = v * 2 + int'(m_bits[i]);
            if (v == int'(PATTERN)) begin
              m_phase   = 1;
              m_shift_n = 0;
              m_delay   = 0;
              m_bits.delete();
            end
          end
        end
      end
      1: begin
        if (ab) begin
          m_phase = 0;
        end else begin
          m_delay = m_delay * 2 + int'(d);
          m_shift_n++;
          if (m_shift_n == DELAY_W) begin
            m_phase = 2;
            m_rem   = (m_delay + 1) * TICK;
          end
        end
      end
      2: begin
        if (ab) begin
          m_phase = 0;
        end else begin
          m_rem--;
          if (m_rem == 0) m_phase = 3;
        end
      end
      default: begin
        if (ab || ak) m_phase = 0;
      end
    endcase
  endfunction

  function automatic logic [DELAY_W+2:0] model_out();
    logic [DELAY_W-1:0] c;
    c = (m_phase == 2) ? DELAY_W'((m_rem - 1) / TICK) : '0;
    return {m_phase == 1, m_phase == 2, m_phase == 3, c};
  endfunction

  // One clock: drive inputs, let the DUT and the model advance, compare just after the edge.
  task automatic step(input logic d, input logic ab, input logic ak, input logic rst);
    logic [DELAY_W+2:0] exp_v, obs_v;
    bus.data  = d;
    bus.abort = ab;
    bus.ack   = ak;
    reset     = rst;
    @(posedge clk);
    model_step(d, ab, ak, rst);
    #1;
    exp_v = model_out();
    obs_v = {bus.shift_ena, bus.counting, bus.done, bus.counting ? bus.count : {DELAY_W{1'b0}}};
    checks++;
    if (obs_v !== exp_v) begin
      failures++;
      $display("FAIL model_lockstep t=%0t got=%b want=%b", $time, obs_v, exp_v);
    end
  endtask

  task automatic send(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_to_done(output int cnt, output bit ok);
    seen_counts.delete();
    cnt = 0;
    if (bus.counting) begin
      cnt = 1;
      seen_counts.push_back(int'(bus.count));
    end
    for (int i = 0; i < 400 && !bus.done; i++) begin
      step(1'($urandom), 1'b0, 1'b0, 1'b0);
      if (bus.counting) begin
        cnt++;
        seen_counts.push_back(int'(bus.count));
      end
    end
    ok = bus.done;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({bus.shift_ena, bus.counting, bus.done, bus.count} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0000000",
               {bus.shift_ena, bus.counting, bus.done, bus.count});
    end
  endtask

  task automatic test_basic();
    int cnt, sh, bad;
    bit ok;
    send(16'b110, 3);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.shift_ena !== 1'b1) begin
      failures++;
      $display("FAIL basic_shift_start got=%b want=1", bus.shift_ena);
    end
    sh = 1;
    for (int i = 3; i >= 0; i--) begin
      step(i[0] ? 1'b0 : 1'b1, 1'b0, 1'b0, 1'b0);  // 0,1,0,1
      sh += int'(bus.shift_ena);
    end
    checks++;
    if (sh != 4 || bus.counting !== 1'b1) begin
      failures++;
      $display("FAIL basic_shift_len got=%0d/%b want=4/1", sh, bus.counting);
    end
    run_to_done(cnt, ok);
    checks++;
    if (!ok || cnt != 24) begin
      failures++;
      $display("FAIL basic_count_len got=%0d done=%b want=24 done=1", cnt, ok);
    end
    bad = -1;
    for (int i = 0; i < 24; i++)
      if (i >= seen_counts.size() || seen_counts[i] != 5 - i / TICK) begin
        bad = i;
        break;
      end
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL basic_count_seq index=%0d got=%0d want=%0d", bad,
               (bad < seen_counts.size()) ? seen_counts[bad] : -1, 5 - bad / TICK);
    end
    for (int i = 0; i < 3; i++) step(1'($urandom), 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.done !== 1'b1) begin
      failures++;
      $display("FAIL basic_done_hold got=%b want=1", bus.done);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({bus.shift_ena, bus.counting, bus.done} !== 3'b000) begin
      failures++;
      $display("FAIL basic_ack_release got=%b want=000", {bus.shift_ena, bus.counting, bus.done});
    end
  endtask

  task automatic test_overlap();
    int cnt;
    bit ok;
    send(16'b1110, 4);
    checks++;
    if (bus.shift_ena !== 1'b0) begin
      failures++;
      $display("FAIL overlap_early got=%b want=0", bus.shift_ena);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.shift_ena !== 1'b1) begin
      failures++;
      $display("FAIL overlap_match got=%b want=1", bus.shift_ena);
    end
    send(16'b0010, 4);
    run_to_done(cnt, ok);
    checks++;
    if (!ok || cnt != 12) begin
      failures++;
      $display("FAIL overlap_count_len got=%0d done=%b want=12 done=1", cnt, ok);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_zero_delay();
    int cnt, nonzero;
    bit ok;
    send(16'b1101, 4);
    send(16'b0000, 4);
    run_to_done(cnt, ok);
    nonzero = 0;
    foreach (seen_counts[i]) if (seen_counts[i] != 0) nonzero++;
    checks++;
    if (!ok || cnt != 4 || nonzero != 0) begin
      failures++;
      $display("FAIL zero_delay got=%0d cycles nonzero=%0d done=%b want=4 cycles nonzero=0 done=1",
               cnt, nonzero, ok);
    end
  endtask

  task automatic test_rearm();
    int cnt, sh;
    bit ok;
    logic [6:0] seq;
    step(1'b0, 1'b0, 1'b1, 1'b0);  // ack in DONE
    seq = 7'b1011101;             // 1,0,1 then 1,1,0,1 with ack held
    sh  = 0;
    for (int i = 6; i >= 1; i--) begin
      step(seq[i], 1'b0, 1'b1, 1'b0);
      sh += int'(bus.shift_ena) + int'(bus.done);
    end
    checks++;
    if (sh != 0) begin
      failures++;
      $display("FAIL rearm_no_early_match got=%0d want=0", sh);
    end
    step(seq[0], 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.shift_ena !== 1'b1) begin
      failures++;
      $display("FAIL rearm_match got=%b want=1", bus.shift_ena);
    end
    send(16'b0001, 4);
    run_to_done(cnt, ok);
    checks++;
    if (!ok || cnt != 8) begin
      failures++;
      $display("FAIL rearm_count_len got=%0d done=%b want=8 done=1", cnt, ok);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_abort();
    int cnt;
    bit ok, hit;
    send(16'b1101, 4);
    send(16'b0101, 4);
    hit = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.counting && bus.count == 4'd3) begin
        hit = 1'b1;
        break;
      end
      step(1'($urandom), 1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL abort_reach_count3 got=%0d want=3", bus.count);
    end
    step(1'($urandom), 1'b1, 1'b0, 1'b0);
    checks++;
    if ({bus.shift_ena, bus.counting, bus.done} !== 3'b000) begin
      failures++;
      $display("FAIL abort_outputs got=%b want=000", {bus.shift_ena, bus.counting, bus.done});
    end
    send(16'b1101, 4);
    send(16'b0001, 4);
    run_to_done(cnt, ok);
    checks++;
    if (!ok || cnt != 8) begin
      failures++;
      $display("FAIL abort_restart_len got=%0d done=%b want=8 done=1", cnt, ok);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_shift();
    int cnt, sh;
    bit ok;
    send(16'b1101, 4);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({bus.shift_ena, bus.counting, bus.done, bus.count} !== 7'b0) begin
      failures++;
      $display("FAIL reset_mid_shift got=%b want=0000000",
               {bus.shift_ena, bus.counting, bus.done, bus.count});
    end
    sh = 0;
    for (int i = 0; i < 3; i++) begin
      step((i == 1) ? 1'b0 : 1'b1, 1'b0, 1'b0, 1'b0);  // 1,0,1
      sh += int'(bus.shift_ena);
    end
    send(16'b110, 3);
    checks++;
    if (sh != 0 || bus.shift_ena !== 1'b0) begin
      failures++;
      $display("FAIL reset_partial_no_match got=%0d/%b want=0/0", sh, bus.shift_ena);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.shift_ena !== 1'b1) begin
      failures++;
      $display("FAIL reset_full_pattern got=%b want=1", bus.shift_ena);
    end
    send(16'($urandom_range(0, 15)), 4);
    run_to_done(cnt, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL reset_recover_done got=%b want=1", ok);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++)
      step(1'($urandom), ($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 299) == 0));
  endtask

  initial begin
    bus.data  = 1'b0;
    bus.abort = 1'b0;
    bus.ack   = 1'b0;
    reset     = 1'b1;
    test_reset();
    test_basic();
    test_overlap();
    test_zero_delay();
    test_rearm();
    test_abort();
    test_reset_mid_shift();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "simulation did not finish");
  end

endmodule
